conv_alu: RTL
=============

CONV_ALU -- requirements
Module: conv_alu

Interface
REQ-001 Parameter: WIDTH, default 24, datapath width; matches GPR and bus width.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  input  3  operation code, latched with start.
REQ-006 Port: a_bus  input  WIDTH  A operand (accumulator), latched with start.
REQ-007 Port: b_bus  input  WIDTH  B operand (GPR selected via B-bus mux), latched with start.
REQ-008 Port: c_bus  output  WIDTH  registered result; drives GPR C_bus inputs.
REQ-009 Port: z_flag  output  1  registered; high when c_bus is zero.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle pulse; c_bus holds the new result in the same cycle.

Function
REQ-012 States SHALL be IDLE, MUL, DONE.
- IDLE to DONE on start with a single-cycle op.
- IDLE to MUL on start with op 101.
- MUL to DONE after WIDTH iterations.
- DONE to IDLE unconditionally.
REQ-013 Opcodes:
- 000: PASS B.
- 001: A+B.
- 010: A-B.
- 011: A+1.
- 100: A >> B[4:0], logical.
- 101: MUL, low WIDTH bits of A*B.
- 110/111: unsupported, result 0.
REQ-014 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation and no carry output.
REQ-015 A shift amount of WIDTH or more SHALL yield 0.
REQ-016 Single-cycle latency: start sampled at edge k; c_bus, z_flag and done valid after edge k+1; busy high for 1 cycle.
REQ-017 MUL SHALL use shift-add, one multiplier bit per cycle, for exactly WIDTH cycles; done is asserted after edge k+WIDTH+1.
REQ-018 start while busy SHALL be ignored and not queued; start in the DONE cycle is also ignored.
REQ-019 Changes on a_bus, b_bus or op after the start edge SHALL NOT affect the result in progress.
REQ-020 c_bus and z_flag SHALL hold their value between done pulses.
REQ-021 done SHALL never be high for two consecutive cycles.

Reset
REQ-022 On rst: state IDLE; c_bus 0; z_flag 1; busy 0; done 0; iteration counter 0; latched operands 0.
REQ-023 rst SHALL override a simultaneous start.
REQ-024 rst mid-MUL SHALL abort the operation with no done pulse.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro CONV_ALU_MUL_EN: when defined, op 101 behaves per REQ-013/REQ-017.
REQ-027 When CONV_ALU_MUL_EN is undefined:
- the MUL state and multiplier logic are absent;
- op 101 is treated as unsupported: result 0, single-cycle latency.

Structure
REQ-028 Shared package conv_alu_pkg SHALL hold the opcode constants, the state encoding and the default width (24).
REQ-029 The shift-add multiplier SHALL be a sub-module seq_mul (ports load, a, b, product, last), instantiated only under CONV_ALU_MUL_EN.

Verification
REQ-030 rst high 2 cycles -> c_bus 0, z_flag 1, busy 0, done 0.
REQ-031 start, op 001, A=0xFFFFFF, B=0x000002 -> next cycle c_bus 0x000001, done 1, z_flag 0; following cycle done 0, busy 0.
REQ-032 start, op 010, A=5, B=5 -> c_bus 0, z_flag 1; then op 100, A=0x000F00, B=8 -> c_bus 0x00000F.
REQ-033 With macro: start, op 101, A=0x000123, B=0x000010 -> busy high 25 cycles, done at cycle 25, c_bus 0x001230. Second start at cycle 10 -> ignored.
REQ-034 With macro: start MUL, rst at cycle 12 -> IDLE, c_bus 0, no done pulse. Without macro: op 101 -> c_bus 0, done at cycle 1.
REQ-035 start, op 111 -> c_bus 0, z_flag 1, done at cycle 1. Operand change after start -> result unaffected.

Source files
------------

// File: rtl/conv_alu_pkg.sv
// Shared opcode constants, FSM encoding and default width for conv_alu.
// Used by conv_alu and seq_mul.
package conv_alu_pkg;

  localparam int DEF_WIDTH = 24;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Shift-add multiplier, one multiplier bit per cycle for WIDTH cycles.
// product is combinational; it holds the full low-WIDTH result while last is high.
module seq_mul
  import conv_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = run_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        cnt_q <= '0;
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_alu.sv
// Sequencer ALU: single-cycle ops plus optional shift-add multiply.
// Multiply is built only when CONV_ALU_MUL_EN is defined.
module conv_alu
  import conv_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] b_bus,
  output logic [WIDTH-1:0] c_bus,
  output logic             z_flag,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic             c_we;
  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       shamt;

  assign shamt = b_bus[4:0];

  // Single-cycle results are captured straight from the buses at the start edge
  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (op == OP_PASS): alu_res = b_bus;
      (op == OP_ADD):  alu_res = a_bus + b_bus;
      (op == OP_SUB):  alu_res = a_bus - b_bus;
      (op == OP_INC):  alu_res = a_bus + WIDTH'(1);
      (op == OP_SHR):  alu_res = (32'(shamt) >= WIDTH) ? '0 : a_bus >> shamt;
      default:         alu_res = '0;
    endcase
  end

`ifdef CONV_ALU_MUL_EN
  logic             mul_load;
  logic [WIDTH-1:0] mul_prod;
  logic             mul_last;

  seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .a      (a_bus),
    .b      (b_bus),
    .product(mul_prod),
    .last   (mul_last)
  );
`endif

  always_comb begin
    state_d = state_q;
    c_we    = 1'b0;
    c_d     = alu_res;
`ifdef CONV_ALU_MUL_EN
    mul_load = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef CONV_ALU_MUL_EN
          if (op == OP_MUL) begin
            state_d  = MUL;
            mul_load = 1'b1;
          end else begin
            state_d = DONE;
            c_we    = 1'b1;
          end
`else
          state_d = DONE;
          c_we    = 1'b1;
`endif
        end
      end
`ifdef CONV_ALU_MUL_EN
      MUL: begin
        if (mul_last) begin
          state_d = DONE;
          c_we    = 1'b1;
          c_d     = mul_prod;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_bus   <= '0;
      z_flag  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (c_we) begin
        c_bus  <= c_d;
        z_flag <= (c_d == '0);
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
